camera_stream_rx: RTL and testbench

// Receive end of the parallel camera pixel interface (fv/lv/pix_en/pix_data) driven by the sensor
// or the image_gen test-pattern source. Tracks per-pixel x/y position and forwards valid pixels

---
 rtl/camera_stream_rx.sv | 171 +++++++++++++++++
 tb/tb_camera_stream_rx.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/camera_stream_rx.sv
`default_nettype none
// ============================================================================
// Module      : camera_stream_rx
// Description : Parallel camera pixel interface receiver. Tracks x/y position,
//               forwards qualified pixels with coordinates and frame/line
//               markers, and checks each frame against HPIX x VPIX.
// Revision    : 1.0 - initial release
// ============================================================================
module camera_stream_rx #(
  parameter int HPIX = 640,
  parameter int VPIX = 400,
  parameter int DW   = 10
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          fv,
  input  logic          lv,
  input  logic          pix_en,
  input  logic [DW-1:0] pix_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic [15:0]   out_x,
  output logic [15:0]   out_y,
  output logic          out_sof,
  output logic          out_eol,
  output logic          frame_done,
  output logic [15:0]   last_width,
  output logic [15:0]   last_height,
  output logic [7:0]    frame_count,
  output logic          err_width,
  output logic          err_height
);

  localparam logic [15:0] c_hpix      = 16'(HPIX);
  localparam logic [15:0] c_vpix      = 16'(VPIX);
  localparam logic [15:0] c_hpix_last = 16'(HPIX - 1);

  typedef enum logic [1:0] {
    ST_SYNC     = 2'd0,
    ST_WAIT     = 2'd1,
    ST_IN_FRAME = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_fv;
  logic          r_lv;
  logic          r_pix_en;
  logic [DW-1:0] r_pix_data;
  logic          r_fv_d;
  logic          r_lv_d;
  logic          r_primed;
  logic          r_first_pix;
  logic [15:0]   r_x;
  logic [15:0]   r_y;

  logic          w_fv_rise;
  logic          w_fv_fall;
  logic          w_lv_fall;
  logic          w_pix;
  logic          w_close;
  logic [15:0]   w_y_closed;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Input capture stage plus one-cycle history for edge detection. r_primed
  // marks that stage 1 holds a real sample rather than the reset value, so
  // the SYNC state cannot mistake reset for a genuine vertical blank.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fv       <= 1'b0;
      r_lv       <= 1'b0;
      r_pix_en   <= 1'b0;
      r_pix_data <= '0;
      r_fv_d     <= 1'b0;
      r_lv_d     <= 1'b0;
      r_primed   <= 1'b0;
    end else begin
      r_fv       <= fv;
      r_lv       <= lv;
      r_pix_en   <= pix_en;
      r_pix_data <= pix_data;
      r_fv_d     <= r_fv;
      r_lv_d     <= r_lv;
      r_primed   <= 1'b1;
    end
  end

  assign w_fv_rise  = r_fv & ~r_fv_d;
  assign w_fv_fall  = ~r_fv & r_fv_d;
  assign w_lv_fall  = ~r_lv & r_lv_d;
  assign w_pix      = r_pix_en & r_lv & r_fv;
  // A line is closed by lv falling or by fv falling; empty lines are blanking.
  assign w_close    = (w_lv_fall | w_fv_fall) & (r_x != 16'd0);
  assign w_y_closed = w_close ? sat_inc(r_y) : r_y;

  // Frame tracking FSM with registered pixel outputs and status pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_SYNC;
      r_first_pix <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_x       <= '0;
      out_y       <= '0;
      out_sof     <= 1'b0;
      out_eol     <= 1'b0;
      frame_done  <= 1'b0;
      last_width  <= '0;
      last_height <= '0;
      frame_count <= '0;
      err_width   <= 1'b0;
      err_height  <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      out_sof    <= 1'b0;
      out_eol    <= 1'b0;
      frame_done <= 1'b0;
      err_width  <= 1'b0;
      err_height <= 1'b0;
      case (r_state)
        ST_SYNC: begin
          if (r_primed && !r_fv) begin
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (w_fv_rise) begin
            r_state     <= ST_IN_FRAME;
            r_x         <= '0;
            r_y         <= '0;
            r_first_pix <= 1'b1;
          end
        end
        ST_IN_FRAME: begin
          if (w_pix) begin
            out_valid   <= 1'b1;
            out_data    <= r_pix_data;
            out_x       <= r_x;
            out_y       <= r_y;
            out_sof     <= r_first_pix;
            out_eol     <= (r_x == c_hpix_last);
            r_first_pix <= 1'b0;
            r_x         <= sat_inc(r_x);
          end
          if (w_close) begin
            last_width <= r_x;
            err_width  <= (r_x != c_hpix);
            r_y        <= w_y_closed;
            r_x        <= '0;
          end
          if (w_fv_fall) begin
            last_height <= w_y_closed;
            frame_count <= frame_count + 8'd1;
            frame_done  <= 1'b1;
            err_height  <= (w_y_closed != c_vpix);
            r_state     <= ST_WAIT;
          end
        end
        default: begin
          r_state <= ST_SYNC;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_camera_stream_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_camera_stream_rx
// Description : Self-checking bench for camera_stream_rx (HPIX=8, VPIX=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_camera_stream_rx;

  localparam int HPIX = 8;
  localparam int VPIX = 4;
  localparam int DW   = 10;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          fv, lv, pix_en;
  logic [DW-1:0] pix_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [15:0]   out_x, out_y;
  logic          out_sof, out_eol, frame_done;
  logic [15:0]   last_width, last_height;
  logic [7:0]    frame_count;
  logic          err_width, err_height;

  camera_stream_rx #(.HPIX(HPIX), .VPIX(VPIX), .DW(DW)) dut (
    .clk(clk), .reset_n(reset_n), .fv(fv), .lv(lv), .pix_en(pix_en),
    .pix_data(pix_data), .out_valid(out_valid), .out_data(out_data),
    .out_x(out_x), .out_y(out_y), .out_sof(out_sof), .out_eol(out_eol),
    .frame_done(frame_done), .last_width(last_width), .last_height(last_height),
    .frame_count(frame_count), .err_width(err_width), .err_height(err_height)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [15:0]   x;
    logic [15:0]   y;
    logic          sof;
    logic          eol;
  } pix_t;

  typedef struct packed {
    logic [15:0] w;
    logic [15:0] h;
    logic        eh;
    logic        ewd;
    logic [7:0]  fc;
  } frm_t;

  typedef struct {
    int   w0, w1, w2, w3;
    int   nlines;
    int   cut_line;
    int   cut_pix;
    int   exp_w;
    int   exp_h;
    logic exp_eh;
    logic exp_ewd;
    int   exp_errw;
  } vec_t;

  pix_t        pq[$];
  frm_t        fq[$];
  logic [15:0] errq[$];
  int          tot = 0;
  int          bad = 0;
  int          errw_seen = 0;
  int          done_seen = 0;
  logic [7:0]  exp_fc = 8'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output monitor: pixels, line errors and frame reports against the queues.
  always @(negedge clk) begin
    if (reset_n) begin
      if (out_valid) begin
        if (pq.size() == 0) chk("unexpected_pixel", 64'd1, 64'd0);
        else chk("pixel", {out_data, out_x, out_y, out_sof, out_eol}, pq.pop_front());
      end
      if (err_width) begin
        errw_seen++;
        if (errq.size() == 0) chk("unexpected_err_width", 64'd1, 64'd0);
        else chk("err_width_last_width", last_width, errq.pop_front());
      end
      if (frame_done) begin
        done_seen++;
        if (fq.size() == 0) chk("unexpected_frame_done", 64'd1, 64'd0);
        else chk("frame_report", {last_width, last_height, err_height, err_width, frame_count},
                 fq.pop_front());
      end
      if (err_height && !frame_done) chk("err_height_without_done", 64'd1, 64'd0);
    end
  end

  task automatic drive_frame(input vec_t v);
    int   w[4];
    pix_t p;
    frm_t f;
    logic cut;
    w   = '{v.w0, v.w1, v.w2, v.w3};
    cut = 1'b0;
    fv  = 1'b1;
    tick(); tick();
    for (int l = 0; l < v.nlines && !cut; l++) begin
      lv = 1'b1;
      for (int i = 0; i < w[l]; i++) begin
        if (l == v.cut_line && i == v.cut_pix) break;
        pix_en   = 1'b1;
        pix_data = DW'($urandom);
        p = '{d: pix_data, x: 16'(i), y: 16'(l), sof: (l == 0 && i == 0), eol: (i == HPIX - 1)};
        pq.push_back(p);
        tick();
      end
      pix_en = 1'b0;
      if (l == v.cut_line) begin
        fv  = 1'b0;
        lv  = 1'b0;
        cut = 1'b1;
        if (v.cut_pix != HPIX) errq.push_back(16'(v.cut_pix));
        tick();
      end else begin
        lv = 1'b0;
        if (w[l] != HPIX) errq.push_back(16'(w[l]));
        tick();
        pix_en = 1'b1;  // qualifier without lv must be ignored
        tick();
        pix_en = 1'b0;
        tick();
      end
    end
    fv = 1'b0;
    exp_fc = exp_fc + 8'd1;
    f = '{w: 16'(v.exp_w), h: 16'(v.exp_h), eh: v.exp_eh, ewd: v.exp_ewd, fc: exp_fc};
    fq.push_back(f);
    repeat (4) tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    fv = 1'b0; lv = 1'b0; pix_en = 1'b0; pix_data = '0;
    pq.delete(); fq.delete(); errq.delete();
    exp_fc = 8'd0;
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (3) tick();
  endtask

  vec_t vecs[4];
  vec_t clean;
  int   errw_before;
  int   done_before;

  initial begin
    vecs[0] = '{8, 8, 8, 8, 4, -1, 0, 8, 4, 1'b0, 1'b0, 0};  // clean frame
    vecs[1] = '{8, 7, 8, 8, 4, -1, 0, 8, 4, 1'b0, 1'b0, 1};  // short second line
    vecs[2] = '{8, 8, 8, 8, 4,  2, 5, 5, 3, 1'b1, 1'b1, 1};  // fv drops mid third line
    vecs[3] = '{8, 8, 9, 8, 4, -1, 0, 8, 4, 1'b0, 1'b0, 1};  // wide line forwarded
    clean   = vecs[0];

    reset_n = 1'b0;
    fv = 1'b0; lv = 1'b0; pix_en = 1'b0; pix_data = '0;
    #12;
    chk("reset_outputs",
        {out_valid, out_data, out_x, out_y, out_sof, out_eol, frame_done,
         err_width, err_height, frame_count},
        64'd0);
    chk("reset_geometry", {last_width, last_height}, 64'd0);
    do_reset();

    for (int k = 0; k < 4; k++) begin
      errw_before = errw_seen;
      drive_frame(vecs[k]);
      chk($sformatf("vec%0d_err_width_count", k), 64'(errw_seen - errw_before),
          64'(vecs[k].exp_errw));
    end

    // Reset released while a frame is already running: that frame is dropped.
    reset_n = 1'b0;
    pq.delete(); fq.delete(); errq.delete();
    exp_fc = 8'd0;
    fv = 1'b1; lv = 1'b1; pix_en = 1'b1;
    repeat (3) tick();
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      lv = (i % 10) < 8;
      pix_en = lv;
      pix_data = DW'($urandom);
      tick();
    end
    fv = 1'b0; lv = 1'b0; pix_en = 1'b0;
    repeat (4) tick();
    chk("discarded_frame_count", frame_count, 64'd0);
    drive_frame(clean);
    chk("resync_frame_count", frame_count, 64'd1);

    // Asynchronous reset during line 1 of a frame.
    fv = 1'b1;
    tick(); tick();
    lv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pix_en = 1'b1;
      pix_data = DW'($urandom);
      pq.push_back('{d: pix_data, x: 16'(i), y: 16'd0, sof: (i == 0), eol: 1'b0});
      tick();
    end
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_outputs",
        {out_valid, out_data, out_x, out_y, out_sof, out_eol, frame_done,
         err_width, err_height, frame_count},
        64'd0);
    chk("async_reset_geometry", {last_width, last_height}, 64'd0);
    pq.delete();
    exp_fc = 8'd0;
    done_before = done_seen;
    fv = 1'b0; lv = 1'b0; pix_en = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (4) tick();
    chk("no_done_after_abort", 64'(done_seen - done_before), 64'd0);
    drive_frame(clean);
    chk("post_abort_frame_count", frame_count, 64'd1);

    // 256 good frames: frame_count wraps back to zero.
    do_reset();
    done_before = done_seen;
    for (int k = 0; k < 256; k++) drive_frame(clean);
    chk("wrap_frame_count", frame_count, 64'd0);
    chk("wrap_done_pulses", 64'(done_seen - done_before), 64'd256);

    chk("pixel_queue_drained", 64'(pq.size()), 64'd0);
    chk("frame_queue_drained", 64'(fq.size()), 64'd0);
    chk("errw_queue_drained", 64'(errq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
`default_nettype wire
